dmem_access_seq: RTL and testbench
==================================

DMEM_ACCESS_SEQ -- requirements
Module: dmem_access_seq

Interface
REQ-001 SHALL have parameter SPLIT_EN, default 1: 1 = split misaligned accesses into two aligned word accesses; 0 = reject them with an error.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port core_req, input, 1: access request, sampled only while core_ready=1.
REQ-005 SHALL have port core_we, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port core_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-007 SHALL have port core_uns, input, 1: 1 = zero-extend load data, 0 = sign-extend.
REQ-008 SHALL have port core_addr, input, 32: byte address.
REQ-009 SHALL have port core_wdata, input, 32: store data, right-justified.
REQ-010 SHALL have port core_ready, output, 1: idle and able to accept a request.
REQ-011 SHALL have port core_done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port core_err, output, 1: error flag, valid only with core_done.
REQ-013 SHALL have port core_rdata, output, 32: extended load result, valid only with core_done on a load.
REQ-014 SHALL have memory ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_be out 4, mem_wdata out 32, mem_gnt in 1, mem_rvalid in 1, mem_rdata in 32.

Function
REQ-015 SHALL capture we, size, uns, addr and wdata when core_req=1 and core_ready=1, and SHALL ignore later changes on the core inputs until core_done.
REQ-016 SHALL use the FSM states IDLE, REQ0, WAIT0, REQ1, WAIT1 and ERR; core_ready=1 only in IDLE.
REQ-017 Definitions: o = addr[1:0]; n = 1, 2 or 4 bytes; split = (o+n > 4).
REQ-018 On accept: size=11, or split with SPLIT_EN=0 -> ERR; otherwise -> REQ0.
REQ-019 In ERR: core_done=1 and core_err=1 for one cycle, no memory access is issued, next state IDLE.
REQ-020 REQ0/REQ1: mem_req SHALL be held at 1 with stable mem_addr, mem_be, mem_we and mem_wdata until mem_gnt=1; on gnt -> WAIT0/WAIT1, and mem_req=0 from the next cycle.
REQ-021 At most one memory access SHALL be outstanding; mem_rvalid SHALL be honoured only in WAIT0/WAIT1 (it also acks stores) and ignored in every other state.
REQ-022 WAIT0 on rvalid: split -> REQ1; otherwise core_done=1 in that same cycle and next state IDLE.
REQ-023 WAIT1 on rvalid: core_done=1 in that same cycle and next state IDLE.
REQ-024 Access 0: mem_addr = {addr[31:2],2'b00}; mem_be = bits [3:0] of ((2^n − 1) << o).
REQ-025 Access 1: mem_addr = access-0 address + 4, wrapping modulo 2^32; mem_be = bits [7:4] of the same 8-bit mask.
REQ-026 Store data: mem_wdata = wdata rotated left by 8·o for both accesses.
REQ-027 Load data: buffer the first rdata; result = ({rdata1,rdata0} >> 8·o), low n bytes kept; rdata1 = 0 when not split.
REQ-028 Load extension: result extended from bit 8n−1, sign or zero per uns; a word load is passed unchanged.
REQ-029 Latency: an aligned access with gnt in the REQ0 cycle and rvalid one cycle later gives core_done 2 cycles after accept; a split access under the same timing takes 4 cycles.
REQ-030 While core_done=1, core_ready SHALL be 0; a new request is accepted no earlier than the following cycle.
REQ-031 Outputs SHALL come from registered state: mem_* a function of state plus captured fields; no combinational path from core_* inputs to mem_*.

Reset
REQ-032 While rst=1 at a clock edge, the FSM SHALL go to IDLE and all captured and buffered registers SHALL be cleared to 0.
REQ-033 Output values after reset: mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, core_done=0, core_err=0, core_rdata=0, core_ready=1.
REQ-034 Reset mid-access SHALL abandon the transaction without a core_done pulse; a late mem_rvalid after reset SHALL be ignored.

Verification
REQ-035 Aligned LW, addr 0x100, gnt immediate, rdata 0xDEADBEEF -> single access, be=1111, core_rdata=0xDEADBEEF, done 2 cycles after accept.
REQ-036 SH, addr 0x203, wdata 0x0000ABCD -> access 0: addr 0x200, be=1000, wdata 0xCDxxxxxx; access 1: addr 0x204, be=0001, wdata[7:0]=0xAB; then done.
REQ-037 LH signed, addr 0x103, rdata0 0x80xxxxxx, rdata1 0xxxxxxxFF -> core_rdata=0xFFFFFF80; the same access with LHU -> 0x0000FF80.
REQ-038 LB, addr 0x7, rdata 0x85xxxxxx; mem_gnt withheld 3 cycles -> mem_req and mem_addr stable across the wait; result 0xFFFFFF85.
REQ-039 SPLIT_EN=0 with LW at addr 0x2, and size=11 at any address -> no mem_req, core_done and core_err pulse the cycle after accept.
REQ-040 rst asserted in WAIT0 of a split access, then a stray rvalid -> IDLE, no core_done, mem_req=0, next request handled normally.

Source files
------------

// File: rtl/dmem_access_seq.sv
// Data-memory access sequencer: turns one core load/store into one or two aligned
// word accesses, with byte-lane steering, load extension and error reporting.
module dmem_access_seq #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [1:0]  core_size,
    input  logic        core_uns,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_ready,
    output logic        core_done,
    output logic        core_err,
    output logic [31:0] core_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, ERR} state_t;

    state_t      state, state_nxt;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata0_q;

    logic [2:0]  in_n, cap_n;
    logic        in_split, cap_split;
    logic [3:0]  byte_mask;
    logic [7:0]  mask8;
    logic [4:0]  sh;
    logic [5:0]  rot_start;
    logic [63:0] wdbl, rd_pair;
    logic [31:0] rd_win, rd_ext;
    logic [31:0] word0_addr;

    always_comb begin
        case (core_size)
            2'b00:   in_n = 3'd1;
            2'b01:   in_n = 3'd2;
            default: in_n = 3'd4;
        endcase
        case (size_q)
            2'b00:   begin cap_n = 3'd1; byte_mask = 4'b0001; end
            2'b01:   begin cap_n = 3'd2; byte_mask = 4'b0011; end
            default: begin cap_n = 3'd4; byte_mask = 4'b1111; end
        endcase
    end

    // o + n > 4 means the bytes straddle a word boundary
    assign in_split   = ({1'b0, core_addr[1:0]} + in_n) > 3'd4;
    assign cap_split  = ({1'b0, addr_q[1:0]} + cap_n) > 3'd4;
    assign mask8      = {4'b0000, byte_mask} << addr_q[1:0];
    assign sh         = {addr_q[1:0], 3'b000};
    assign word0_addr = {addr_q[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata0_q <= 32'h0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && core_req) begin
                we_q    <= core_we;
                uns_q   <= core_uns;
                size_q  <= core_size;
                addr_q  <= core_addr;
                wdata_q <= core_wdata;
            end
            if (state == WAIT0 && mem_rvalid) begin
                rdata0_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        core_ready = 1'b0;
        core_done  = 1'b0;
        core_err   = 1'b0;
        mem_req    = 1'b0;
        case (state)
            IDLE: begin
                core_ready = 1'b1;
                if (core_req) begin
                    if (core_size == 2'b11 || (!SPLIT_EN && in_split)) state_nxt = ERR;
                    else                                               state_nxt = REQ0;
                end
            end
            REQ0: begin
                mem_req = 1'b1;
                if (mem_gnt) state_nxt = WAIT0;
            end
            WAIT0: begin
                if (mem_rvalid) begin
                    if (cap_split) begin
                        state_nxt = REQ1;
                    end else begin
                        core_done = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            REQ1: begin
                mem_req = 1'b1;
                if (mem_gnt) state_nxt = WAIT1;
            end
            WAIT1: begin
                if (mem_rvalid) begin
                    core_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ERR: begin
                core_done = 1'b1;
                core_err  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Store lanes: rotate left by the byte offset; the same image serves both accesses
    assign wdbl      = {wdata_q, wdata_q};
    assign rot_start = 6'd32 - {1'b0, sh};

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_be    = 4'h0;
        mem_wdata = 32'h0;
        if (mem_req) begin
            mem_we    = we_q;
            mem_addr  = (state == REQ1) ? word0_addr + 32'd4 : word0_addr;
            mem_be    = (state == REQ1) ? mask8[7:4] : mask8[3:0];
            mem_wdata = wdbl[rot_start +: 32];
        end
    end

    // Load path: second word is live rdata in WAIT1, zero for a single access
    always_comb begin
        rd_pair = (state == WAIT1) ? {mem_rdata, rdata0_q} : {32'h0, mem_rdata};
        rd_win  = rd_pair[{1'b0, sh} +: 32];
        case (size_q)
            2'b00:   rd_ext = {{24{~uns_q & rd_win[7]}},  rd_win[7:0]};
            2'b01:   rd_ext = {{16{~uns_q & rd_win[15]}}, rd_win[15:0]};
            default: rd_ext = rd_win;
        endcase
        core_rdata = (core_done && !core_err && !we_q) ? rd_ext : 32'h0;
    end

endmodule

// File: tb/tb_dmem_access_seq.sv
// Randomized bench for dmem_access_seq: byte-level reference memory, a word memory
// responder with random grant/response delays, plus directed corner cases.
module tb_dmem_access_seq;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        core_req, core_we, core_uns;
    logic [1:0]  core_size;
    logic [31:0] core_addr, core_wdata;
    logic        core_ready, core_done, core_err;
    logic [31:0] core_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        resp_rv, stray_rv;
    assign mem_rvalid = resp_rv | stray_rv;

    dmem_access_seq #(.SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_size(core_size), .core_uns(core_uns),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ready(core_ready), .core_done(core_done), .core_err(core_err), .core_rdata(core_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // Second instance with splitting disabled; its memory always grants and always responds
    logic        b_req, b_we, b_uns;
    logic [1:0]  b_size;
    logic [31:0] b_addr, b_wdata;
    logic        b_ready, b_done, b_err;
    logic [31:0] b_rdata;
    logic        b_mem_req, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_be;
    logic        b_gnt = 1'b1, b_rvalid = 1'b1;
    logic [31:0] b_mrdata = 32'h1234_5678;

    dmem_access_seq #(.SPLIT_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .core_req(b_req), .core_we(b_we), .core_size(b_size), .core_uns(b_uns),
        .core_addr(b_addr), .core_wdata(b_wdata),
        .core_ready(b_ready), .core_done(b_done), .core_err(b_err), .core_rdata(b_rdata),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_be(b_mem_be),
        .mem_wdata(b_mem_wdata), .mem_gnt(b_gnt), .mem_rvalid(b_rvalid), .mem_rdata(b_mrdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- memory models ----------------
    logic [31:0] wmem [logic [29:0]];
    logic [7:0]  bmem [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [29:0] wi);
        return ({2'b00, wi} * 32'h9E37_79B1) ^ 32'h5A3C_C3A5;
    endfunction

    function automatic logic [31:0] rd_word(input logic [29:0] wi);
        if (wmem.exists(wi)) return wmem[wi];
        return init_word(wi);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (bmem.exists(a)) return bmem[a];
        w = init_word(a[31:2]);
        return w[8*a[1:0] +: 8];
    endfunction

    task automatic poke_byte(input logic [31:0] a, input logic [7:0] v);
        logic [31:0] w;
        w = rd_word(a[31:2]);
        w[8*a[1:0] +: 8] = v;
        wmem[a[31:2]] = w;
        bmem[a] = v;
    endtask

    // ---------------- memory responder ----------------
    typedef struct {logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;} acc_t;
    acc_t accq[$];
    int   gmin = 0, gmax = 0, rvmax = 0;
    bit   hold_rv = 1'b0;
    bit   req_seen, waited, pend;
    int   gwait, rdly;
    logic [31:0] first_addr, pdata;
    logic [3:0]  first_be;

    initial begin
        mem_gnt = 1'b0; resp_rv = 1'b0; mem_rdata = 32'h0;
        req_seen = 1'b0; waited = 1'b0; pend = 1'b0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0;
            resp_rv = 1'b0;
            if (rst) begin
                pend = 1'b0;
                req_seen = 1'b0;
            end else if (pend) begin
                chk("req_drop", {31'b0, mem_req}, 32'd0);
                if (!hold_rv) begin
                    if (rdly == 0) begin
                        resp_rv = 1'b1;
                        mem_rdata = pdata;
                        pend = 1'b0;
                    end else begin
                        rdly--;
                    end
                end
            end else if (mem_req) begin
                if (!req_seen) begin
                    req_seen = 1'b1;
                    waited = 1'b0;
                    gwait = $urandom_range(gmax, gmin);
                    first_addr = mem_addr;
                    first_be = mem_be;
                end
                if (gwait == 0) begin
                    if (waited) begin
                        chk("req_stable_addr", mem_addr, first_addr);
                        chk("req_stable_be", {28'b0, mem_be}, {28'b0, first_be});
                    end
                    mem_gnt = 1'b1;
                    req_seen = 1'b0;
                    accq.push_back('{mem_addr, mem_be, mem_we, mem_wdata});
                    if (mem_we) begin
                        logic [31:0] w;
                        w = rd_word(mem_addr[31:2]);
                        for (int k = 0; k < 4; k++)
                            if (mem_be[k]) w[8*k +: 8] = mem_wdata[8*k +: 8];
                        wmem[mem_addr[31:2]] = w;
                        pdata = $urandom;
                    end else begin
                        pdata = rd_word(mem_addr[31:2]);
                    end
                    pend = 1'b1;
                    rdly = $urandom_range(rvmax, 0);
                end else begin
                    waited = 1'b1;
                    gwait--;
                end
            end
        end
    end

    // ---------------- transaction driver (main instance) ----------------
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat);
        int n, lat, n_acc;
        bit done, exp_err, split;
        logic [31:0] val, exp_rd, base, wexp;
        logic [3:0]  be_exp;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        exp_err = (size == 2'b11);
        split = (int'(addr[1:0]) + n) > 4;
        n_acc = exp_err ? 0 : (split ? 2 : 1);

        @(negedge clk); #1;
        chk("ready_idle", {31'b0, core_ready}, 32'd1);
        accq.delete();
        core_req = 1'b1; core_we = we; core_size = size; core_uns = uns;
        core_addr = addr; core_wdata = wdata;
        @(posedge clk); #1;
        core_req = 1'b0; core_we = $urandom; core_size = $urandom; core_uns = $urandom;
        core_addr = $urandom; core_wdata = $urandom;

        lat = 0; done = 1'b0;
        while (!done && lat < 60) begin
            @(negedge clk); #1;
            lat++;
            if (core_done) done = 1'b1;
        end
        chk("done_seen", {31'b0, done}, 32'd1);
        if (!done) return;
        chk("ready_while_done", {31'b0, core_ready}, 32'd0);
        chk("err", {31'b0, core_err}, {31'b0, exp_err});
        if (exp_lat > 0) chk("latency", lat, exp_lat);

        if (!we && !exp_err) begin
            val = 32'h0;
            for (int i = 0; i < n; i++) val[8*i +: 8] = ref_byte(addr + i);
            exp_rd = val;
            if (!uns && n < 4 && val[8*n-1]) exp_rd = val | (32'hFFFF_FFFF << (8*n));
            chk("rdata", core_rdata, exp_rd);
        end

        chk("n_access", accq.size(), n_acc);
        base = {addr[31:2], 2'b00};
        for (int k = 0; k < accq.size() && k < n_acc; k++) begin
            be_exp = 4'h0;
            for (int j = 0; j < 4; j++) begin
                logic [31:0] d;
                d = (base + 32'(4*k) + 32'(j)) - addr;
                if (d < 32'(n)) be_exp[j] = 1'b1;
            end
            chk("acc_addr", accq[k].addr, base + 32'(4*k));
            chk("acc_be", {28'b0, accq[k].be}, {28'b0, be_exp});
            chk("acc_we", {31'b0, accq[k].we}, {31'b0, we});
        end

        if (we && !exp_err) begin
            for (int i = 0; i < n; i++) bmem[addr + i] = wdata[8*i +: 8];
            for (int k = 0; k < n_acc; k++) begin
                logic [31:0] wa;
                wa = base + 32'(4*k);
                for (int j = 0; j < 4; j++) wexp[8*j +: 8] = ref_byte(wa + j);
                chk("mem_word", rd_word(wa[31:2]), wexp);
            end
        end
    endtask

    // ---------------- driver for the no-split instance ----------------
    task automatic run_b(input logic [1:0] size, input logic [31:0] addr, input bit exp_err,
                         input int exp_lat, input logic [31:0] exp_rd);
        int lat;
        bit done, saw_req;
        @(negedge clk); #1;
        b_req = 1'b1; b_we = 1'b0; b_size = size; b_uns = 1'b0; b_addr = addr; b_wdata = 32'h0;
        @(posedge clk); #1;
        b_req = 1'b0; b_size = $urandom; b_addr = $urandom;
        lat = 0; done = 1'b0; saw_req = 1'b0;
        while (!done && lat < 20) begin
            @(negedge clk); #1;
            lat++;
            if (b_mem_req) saw_req = 1'b1;
            if (b_done) done = 1'b1;
        end
        chk("b_done_seen", {31'b0, done}, 32'd1);
        if (!done) return;
        chk("b_err", {31'b0, b_err}, {31'b0, exp_err});
        chk("b_latency", lat, exp_lat);
        if (exp_err) chk("b_no_mem_req", {31'b0, saw_req}, 32'd0);
        else         chk("b_rdata", b_rdata, exp_rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stray_rv = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_size = 2'b00; core_uns = 1'b0;
        core_addr = 32'h0; core_wdata = 32'h0;
        b_req = 1'b0; b_we = 1'b0; b_size = 2'b00; b_uns = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_core_done", {31'b0, core_done}, 32'd0);
        chk("rst_core_err", {31'b0, core_err}, 32'd0);
        chk("rst_core_rdata", core_rdata, 32'd0);
        chk("rst_core_ready", {31'b0, core_ready}, 32'd1);

        // aligned word load, immediate timing
        gmin = 0; gmax = 0; rvmax = 0;
        for (int i = 0; i < 4; i++) poke_byte(32'h100 + i, 8'(32'hDEADBEEF >> (8*i)));
        run_txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 2);
        chk("lw_const", core_rdata, 32'hDEAD_BEEF);

        // split halfword store
        run_txn(1'b1, 2'b01, 1'b0, 32'h203, 32'h0000_ABCD, 4);
        if (accq.size() == 2) begin
            chk("sh_wd0", {24'b0, accq[0].wdata[31:24]}, 32'hCD);
            chk("sh_wd1", {24'b0, accq[1].wdata[7:0]}, 32'hAB);
        end

        // split halfword loads, signed and unsigned
        poke_byte(32'h103, 8'h80);
        poke_byte(32'h104, 8'hFF);
        run_txn(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 4);
        chk("lh_const", core_rdata, 32'hFFFF_FF80);
        run_txn(1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 4);
        chk("lhu_const", core_rdata, 32'h0000_FF80);

        // byte load with grant withheld for three cycles
        poke_byte(32'h7, 8'h85);
        gmin = 3; gmax = 3;
        run_txn(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 5);
        chk("lb_const", core_rdata, 32'hFFFF_FF85);

        // illegal size on the main instance
        gmin = 0; gmax = 0;
        run_txn(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1);

        // reset while waiting for the first response of a split access
        hold_rv = 1'b1;
        @(negedge clk); #1;
        core_req = 1'b1; core_we = 1'b0; core_size = 2'b10; core_uns = 1'b0; core_addr = 32'h1001;
        @(posedge clk); #1;
        core_req = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("rst_mid_in_wait", {31'b0, mem_req}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        stray_rv = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stray_no_done", {31'b0, core_done}, 32'd0);
            chk("stray_no_req", {31'b0, mem_req}, 32'd0);
            chk("stray_ready", {31'b0, core_ready}, 32'd1);
            @(negedge clk);
        end
        stray_rv = 1'b0;
        hold_rv = 1'b0;
        run_txn(1'b0, 2'b10, 1'b0, 32'h1001, 32'h0, 4);

        // no-split instance
        run_b(2'b10, 32'h2,  1'b1, 1, 32'h0);
        run_b(2'b01, 32'h3,  1'b1, 1, 32'h0);
        run_b(2'b11, 32'h8,  1'b1, 1, 32'h0);
        run_b(2'b10, 32'h10, 1'b0, 2, 32'h1234_5678);
        run_b(2'b00, 32'h3,  1'b0, 2, 32'h0000_0012);
        run_b(2'b01, 32'h2,  1'b0, 2, 32'h0000_1234);

        // randomized traffic, including wrap at the top of the address space
        gmin = 0; gmax = 3; rvmax = 2;
        for (int t = 0; t < 250; t++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            a  = ($urandom_range(4, 0) == 0) ? (32'hFFFF_FFFC + $urandom_range(3, 0))
                                             : (32'h1000 + $urandom_range(63, 0));
            sz = ($urandom_range(7, 0) == 0) ? 2'b11 : 2'($urandom_range(2, 0));
            run_txn(1'($urandom), sz, 1'($urandom), a, $urandom, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
